mmio_bus_ctrl: RTL and testbench
================================

Name: mmio_bus_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the processor bus and up to NSLOT peripheral slots (RAM, LEDs, seven-segment display, input port, ...).
- Decodes the top SELW address bits to select a slot.
- Registers the address and write data, issues a one-cycle write or read strobe to the selected slot, and inserts WAIT_CYC read wait states.
- Returns registered read data with a one-cycle Done pulse. Unmapped accesses and access-rule violations are flagged with Err.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- NSLOT, 4, number of slots; legal range 1..2**SELW.
- SELW, 4, number of top address bits (ADDR[AW-1:AW-SELW]) used as the slot index.
- WAIT_CYC, 1, read wait states after the strobe; legal range 0..15.
- RO_MASK, 0, NSLOT-bit mask; bit i = 1 makes slot i read-only, so a write to it is an error.
- WO_MASK, 0, NSLOT-bit mask; bit i = 1 makes slot i write-only, so a read from it is an error.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  access request, sampled only in IDLE.
- W  in  1  1 = write, 0 = read; sampled with Req.
- ADDR  in  AW  access address; sampled with Req.
- DOUT  in  DW  processor write data; sampled with Req.
- DIN  out  DW  registered read data to the processor.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid only while Done=1; 1 = access failed.
- Busy  out  1  high in every state except IDLE.
- BusAddr  out  AW  latched address, driven to all slots.
- BusData  out  DW  latched write data, driven to all slots.
- SlotWr  out  NSLOT  one-hot write strobe.
- SlotRd  out  NSLOT  one-hot read strobe.
- SlotData  in  NSLOT*DW  slot read data; slot i occupies bits [i*DW +: DW].

Behaviour:
- Reset (asynchronous, any state): state=IDLE; DIN=0, Done=0, Err=0, Busy=0, BusAddr=0, BusData=0, SlotWr=0, SlotRd=0; wait counter=0. An access in flight is abandoned and no Done is issued.
- Decode: sel = ADDR[AW-1:AW-SELW]. The access is illegal if any of these hold:
  - sel >= NSLOT (unmapped);
  - W=1 and RO_MASK[sel]=1;
  - W=0 and WO_MASK[sel]=1.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Req=1 → latch ADDR into BusAddr, DOUT into BusData, and latch W and sel.
  - If the access is illegal → go to RESP with the error flag set; otherwise → go to ACCESS.
  - Req=0 → stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Write: SlotWr[sel]=1 → go to RESP.
  - Read: SlotRd[sel]=1. If WAIT_CYC=0, capture SlotData[sel] into DIN at the end of this cycle → go to RESP. Otherwise load counter=WAIT_CYC → go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where counter==1, capture SlotData[sel] into DIN → go to RESP.
  - No strobes are asserted in WAIT.
- RESP (1 cycle): Done=1; Err = latched error flag → go to IDLE. Req in this cycle is ignored; the earliest new request is accepted in the following IDLE cycle.
- Latency, with Req sampled at edge t:
  - Strobe is high in cycle t+1.
  - Write: Done in cycle t+2.
  - Read: Done in cycle t+2+WAIT_CYC.
  - Illegal access: Done=Err=1 in cycle t+1, and no strobe is ever asserted.
- DIN:
  - Holds its last value across writes.
  - Cleared to 0 on an illegal read.
  - Changes only on a read capture, an illegal read, or reset.
- Req while Busy=1 is ignored, with no queuing. ADDR, W and DOUT changing after acceptance have no effect.
- SlotWr and SlotRd are never both non-zero, and at most one bit of either is ever set.
- BusAddr and BusData hold their values until the next accepted Req.

Test Plan:
- Reset mid-read: Req read ADDR=16'h0040, assert Reset in the WAIT cycle → DIN=0, Busy=0, Done never asserted, state IDLE; then a read of ADDR=16'h0040 with SlotData[0]=16'h1234 completes normally.
- Write to slot 1 (defaults): Req at t, W=1, ADDR=16'h1005, DOUT=16'hBEEF → SlotWr=4'b0010 in t+1 only, BusData=16'hBEEF, BusAddr=16'h1005, Done=1/Err=0 at t+2, DIN unchanged.
- Read slot 3 with WAIT_CYC=1: SlotData[3]=16'h00A5, Req at t, ADDR=16'h3000 → SlotRd=4'b1000 at t+1, Done at t+3, DIN=16'h00A5.
- Unmapped address: read of ADDR=16'h7000 → Done=Err=1 at t+1, SlotRd/SlotWr stay 0, DIN=0.
- Access masks with RO_MASK=4'b1000: write to ADDR=16'h3000 → Err=1, no SlotWr pulse. With WO_MASK=4'b0010: read of ADDR=16'h1000 → Err=1, no SlotRd pulse.
- Request handling: Req held high continuously → accesses are accepted only from IDLE, one per 3 cycles for writes; a Req pulse during WAIT is dropped.
- WAIT_CYC=0 build: a read gives Done at t+2 with the data captured in the ACCESS cycle.

Source files
------------

// File: rtl/mmio_bus_ctrl_if.sv
// Processor-side request/response and slot-side strobe/data signals of the MMIO controller.
// The controller binds to the slave modport; the processor/slot model side uses master.
interface mmio_bus_ctrl_if #(
   parameter int AW    = 16,
   parameter int DW    = 16,
   parameter int NSLOT = 4
);
   logic                  req;
   logic                  w;
   logic [AW-1:0]         addr;
   logic [DW-1:0]         dout;
   logic [DW-1:0]         din;
   logic                  done;
   logic                  err;
   logic                  busy;
   logic [AW-1:0]         bus_addr;
   logic [DW-1:0]         bus_data;
   logic [NSLOT-1:0]      slot_wr;
   logic [NSLOT-1:0]      slot_rd;
   logic [NSLOT*DW-1:0]   slot_data;

   modport slave (
      input  req, w, addr, dout, slot_data,
      output din, done, err, busy, bus_addr, bus_data, slot_wr, slot_rd
   );

   modport master (
      output req, w, addr, dout, slot_data,
      input  din, done, err, busy, bus_addr, bus_data, slot_wr, slot_rd
   );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped I/O controller: decodes the top address bits to a slot, issues one-cycle
// write/read strobes, inserts read wait states and returns data with a Done/Err pulse.
module mmio_bus_ctrl #(
   parameter int               AW       = 16,
   parameter int               DW       = 16,
   parameter int               NSLOT    = 4,
   parameter int               SELW     = 4,
   parameter int               WAIT_CYC = 1,
   parameter logic [NSLOT-1:0] RO_MASK  = '0,
   parameter logic [NSLOT-1:0] WO_MASK  = '0
) (
   input  logic           clk,
   input  logic           rst,
   mmio_bus_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   // Masks widened to the full select space so any decoded index is in range.
   localparam int              NSEL      = 2**SELW;
   localparam logic [NSEL-1:0] MAP_EXT   = NSEL'({NSLOT{1'b1}});
   localparam logic [NSEL-1:0] RO_EXT    = NSEL'(RO_MASK);
   localparam logic [NSEL-1:0] WO_EXT    = NSEL'(WO_MASK);
   localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYC);

   state_t            state, state_nxt;
   logic [SELW-1:0]   sel_in, sel_q;
   logic              w_q, err_q;
   logic [3:0]        cnt_q;
   logic [AW-1:0]     bus_addr_q;
   logic [DW-1:0]     bus_data_q, din_q;
   logic              req_ok, illegal, capture;
   logic [NSLOT-1:0]  sel_oh;
   logic [DW-1:0]     slot_rdata;

   function automatic logic access_illegal(input logic [SELW-1:0] s, input logic wr);
      return !MAP_EXT[s] || (wr && RO_EXT[s]) || (!wr && WO_EXT[s]);
   endfunction

   assign sel_in     = bus.addr[AW-1 -: SELW];
   assign illegal    = access_illegal(sel_in, bus.w);
   assign req_ok     = (state == IDLE) && bus.req;
   assign slot_rdata = bus.slot_data[int'(sel_q)*DW +: DW];
   assign capture    = ((state == ACCESS) && !w_q && (WAIT_CYC == 0)) ||
                       ((state == WAIT) && (cnt_q == 4'd1));

   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < NSLOT; i++) sel_oh[i] = (sel_q == SELW'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.slot_wr = '0;
      bus.slot_rd = '0;
      case (state)
         IDLE:   if (bus.req) state_nxt = illegal ? RESP : ACCESS;
         ACCESS: begin
            if (w_q) begin
               bus.slot_wr = sel_oh;
               state_nxt   = RESP;
            end else begin
               bus.slot_rd = sel_oh;
               state_nxt   = (WAIT_CYC == 0) ? RESP : WAIT;
            end
         end
         WAIT:   if (cnt_q == 4'd1) state_nxt = RESP;
         RESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.done     = (state == RESP);
   assign bus.err      = (state == RESP) && err_q;
   assign bus.busy     = (state != IDLE);
   assign bus.bus_addr = bus_addr_q;
   assign bus.bus_data = bus_data_q;
   assign bus.din      = din_q;

   // Request latch, wait counter and read-data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_addr_q <= '0;
         bus_data_q <= '0;
         w_q        <= 1'b0;
         sel_q      <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         din_q      <= '0;
      end else begin
         if (req_ok) begin
            bus_addr_q <= bus.addr;
            bus_data_q <= bus.dout;
            w_q        <= bus.w;
            sel_q      <= sel_in;
            err_q      <= illegal;
            if (illegal && !bus.w) din_q <= '0;
         end
         if ((state == ACCESS) && !w_q) cnt_q <= WAIT_INIT;
         else if (state == WAIT)        cnt_q <= cnt_q - 4'd1;
         if (capture) din_q <= slot_rdata;
      end
   end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: three builds (defaults; access masks with long wait; no wait, 3 slots)
// driven in lockstep and checked per cycle against a transaction-level latency/data model.
module tb_mmio_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, w;
   logic [15:0] addr, dout;
   logic [63:0] slot_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mmio_bus_ctrl_if #(.AW(16), .DW(16), .NSLOT(4)) if0 ();
   mmio_bus_ctrl_if #(.AW(16), .DW(16), .NSLOT(4)) if1 ();
   mmio_bus_ctrl_if #(.AW(16), .DW(16), .NSLOT(3)) if2 ();

   mmio_bus_ctrl #(.WAIT_CYC(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   mmio_bus_ctrl #(.WAIT_CYC(3), .RO_MASK(4'b1000), .WO_MASK(4'b0010))
      u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   mmio_bus_ctrl #(.NSLOT(3), .WAIT_CYC(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

   assign if0.req = req;  assign if0.w = w;  assign if0.addr = addr;  assign if0.dout = dout;
   assign if1.req = req;  assign if1.w = w;  assign if1.addr = addr;  assign if1.dout = dout;
   assign if2.req = req;  assign if2.w = w;  assign if2.addr = addr;  assign if2.dout = dout;
   assign if0.slot_data = slot_data;
   assign if1.slot_data = slot_data;
   assign if2.slot_data = slot_data[47:0];

   logic [15:0] o_din [3];
   logic [15:0] o_ba  [3];
   logic [15:0] o_bd  [3];
   logic [3:0]  o_wr  [3];
   logic [3:0]  o_rd  [3];
   logic        o_done[3];
   logic        o_err [3];
   logic        o_busy[3];

   assign o_din[0] = if0.din;  assign o_din[1] = if1.din;  assign o_din[2] = if2.din;
   assign o_ba[0]  = if0.bus_addr;  assign o_ba[1] = if1.bus_addr;  assign o_ba[2] = if2.bus_addr;
   assign o_bd[0]  = if0.bus_data;  assign o_bd[1] = if1.bus_data;  assign o_bd[2] = if2.bus_data;
   assign o_wr[0]  = if0.slot_wr;  assign o_wr[1] = if1.slot_wr;  assign o_wr[2] = {1'b0, if2.slot_wr};
   assign o_rd[0]  = if0.slot_rd;  assign o_rd[1] = if1.slot_rd;  assign o_rd[2] = {1'b0, if2.slot_rd};
   assign o_done[0] = if0.done;  assign o_done[1] = if1.done;  assign o_done[2] = if2.done;
   assign o_err[0]  = if0.err;   assign o_err[1]  = if1.err;   assign o_err[2]  = if2.err;
   assign o_busy[0] = if0.busy;  assign o_busy[1] = if1.busy;  assign o_busy[2] = if2.busy;

   // Reference model: build parameters and the last read data each build returned.
   logic [15:0] din_m[3];

   function automatic int wc_of(int d);
      return (d == 0) ? 1 : (d == 1) ? 3 : 0;
   endfunction
   function automatic int ns_of(int d);
      return (d == 2) ? 3 : 4;
   endfunction
   function automatic logic [3:0] ro_of(int d);
      return (d == 1) ? 4'b1000 : 4'b0000;
   endfunction
   function automatic logic [3:0] wo_of(int d);
      return (d == 1) ? 4'b0010 : 4'b0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s.din.d%0d", tag, d),  32'(o_din[d]),  32'h0);
         chk($sformatf("%s.done.d%0d", tag, d), 32'(o_done[d]), 32'h0);
         chk($sformatf("%s.err.d%0d", tag, d),  32'(o_err[d]),  32'h0);
         chk($sformatf("%s.busy.d%0d", tag, d), 32'(o_busy[d]), 32'h0);
         chk($sformatf("%s.baddr.d%0d", tag, d), 32'(o_ba[d]),  32'h0);
         chk($sformatf("%s.bdata.d%0d", tag, d), 32'(o_bd[d]),  32'h0);
         chk($sformatf("%s.wr.d%0d", tag, d),   32'(o_wr[d]),   32'h0);
         chk($sformatf("%s.rd.d%0d", tag, d),   32'(o_rd[d]),   32'h0);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // One access from the all-idle state; abort=1 asserts reset in the cycle after the strobe.
   task automatic do_txn(input logic tw, input logic [15:0] ta, input logic [15:0] td,
                         input bit abort);
      int          sel;
      int          lat[3];
      bit          ill[3];
      int          min_l, max_l;
      logic [63:0] sd[8];
      logic [3:0]  m;
      sel   = int'(ta[15:12]);
      min_l = 99;
      max_l = 0;
      for (int d = 0; d < 3; d++) begin
         m = tw ? ro_of(d) : wo_of(d);
         ill[d] = (sel >= ns_of(d)) ? 1'b1 : m[sel];
         lat[d] = ill[d] ? 1 : (tw ? 2 : 2 + wc_of(d));
         if (lat[d] < min_l) min_l = lat[d];
         if (lat[d] > max_l) max_l = lat[d];
      end
      req = 1'b1;  w = tw;  addr = ta;  dout = td;
      slot_data = rand64();
      sd[0] = slot_data;
      for (int k = 1; k <= max_l + 1; k++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++) begin
            if (k == lat[d] && !tw)
               din_m[d] = ill[d] ? 16'h0 : sd[1 + wc_of(d)][sel*16 +: 16];
            chk($sformatf("wr.d%0d.k%0d", d, k), 32'(o_wr[d]),
                (k == 1 && !ill[d] && tw) ? (32'h1 << sel) : 32'h0);
            chk($sformatf("rd.d%0d.k%0d", d, k), 32'(o_rd[d]),
                (k == 1 && !ill[d] && !tw) ? (32'h1 << sel) : 32'h0);
            chk($sformatf("done.d%0d.k%0d", d, k), 32'(o_done[d]), 32'(k == lat[d]));
            chk($sformatf("err.d%0d.k%0d", d, k),  32'(o_err[d]),  32'(k == lat[d] && ill[d]));
            chk($sformatf("busy.d%0d.k%0d", d, k), 32'(o_busy[d]), 32'(k <= lat[d]));
            chk($sformatf("baddr.d%0d.k%0d", d, k), 32'(o_ba[d]), 32'(ta));
            chk($sformatf("bdata.d%0d.k%0d", d, k), 32'(o_bd[d]), 32'(td));
            chk($sformatf("din.d%0d.k%0d", d, k),  32'(o_din[d]), 32'(din_m[d]));
         end
         if (abort && k == 2) begin
            req = 1'b0;
            #1 rst = 1'b1;
            #1;
            chk_reset_outputs("abort");
            for (int d = 0; d < 3; d++) din_m[d] = 16'h0;
            @(posedge clk);
            #1 rst = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(posedge clk);
               #1;
               for (int d = 0; d < 3; d++) begin
                  chk($sformatf("abort.done.d%0d", d), 32'(o_done[d]), 32'h0);
                  chk($sformatf("abort.busy.d%0d", d), 32'(o_busy[d]), 32'h0);
               end
            end
            return;
         end
         // Every build is still busy here, so new request noise must be ignored.
         req  = (k <= min_l) ? 1'($urandom_range(0, 1)) : 1'b0;
         w    = 1'($urandom_range(0, 1));
         addr = 16'($urandom);
         dout = 16'($urandom);
         slot_data = rand64();
         if (k < 8) sd[k] = slot_data;
      end
   endtask

   initial begin
      logic [15:0] ra;
      rst = 1'b1;
      req = 1'b0;  w = 1'b0;  addr = '0;  dout = '0;
      slot_data = '0;
      for (int d = 0; d < 3; d++) din_m[d] = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_txn(1'b1, 16'h1005, 16'hBEEF, 1'b0);
      do_txn(1'b0, 16'h3000, 16'h0000, 1'b0);
      do_txn(1'b0, 16'h7000, 16'h1111, 1'b0);
      do_txn(1'b1, 16'h3000, 16'h2222, 1'b0);
      do_txn(1'b0, 16'h1000, 16'h3333, 1'b0);
      do_txn(1'b0, 16'h2abc, 16'h4444, 1'b0);
      do_txn(1'b0, 16'h0040, 16'h5555, 1'b1);
      do_txn(1'b0, 16'h0040, 16'h6666, 1'b0);
      do_txn(1'b1, 16'hF123, 16'h7777, 1'b0);

      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         if ($urandom_range(0, 7) != 0) ra[15:12] = 4'($urandom_range(0, 3));
         do_txn(1'($urandom_range(0, 1)), ra, 16'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
